// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU writeback scheduler: unit latencies, the
// unit-select enum and the writeback reservation record.
package fpu_sched_pkg;

    localparam int unsigned FMA_LAT     = 4;
    localparam int unsigned FAST_LAT    = 2;
    localparam int unsigned FROMINT_LAT = 2;
    localparam int unsigned TOINT_LAT   = 1;
    localparam int unsigned SLOT_DEPTH  = 4;
    localparam int unsigned SLOT_IDX_W  = $clog2(SLOT_DEPTH);

    typedef enum logic [2:0] {
        NONE,
        FMA,
        FAST,
        FROMINT,
        TOINT
    } unit_e;

    typedef struct packed {
        logic       valid;
        logic [5:0] tag;
        logic [1:0] type_tag;
        logic       wflags;
    } wb_slot_t;

    // Fixed priority: fma > fastpipe > fromint > toint.
    function automatic unit_e unit_select(input logic fma, input logic fast,
                                          input logic fromint, input logic toint);
        unit_e u;
        if (fma)          u = FMA;
        else if (fast)    u = FAST;
        else if (fromint) u = FROMINT;
        else if (toint)   u = TOINT;
        else              u = NONE;
        return u;
    endfunction

endpackage

// File: rtl/fpu_wb_shift_reg.sv
// FP writeback reservation shift register: shifts toward slot 0 every cycle,
// with an optional parallel insert at any index and a synchronous clear.
module fpu_wb_shift_reg
    import fpu_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_ins_en,
    input  logic [SLOT_IDX_W-1:0] i_ins_idx,
    input  wb_slot_t              i_ins_slot,
    output wb_slot_t              o_head,
    output logic [SLOT_DEPTH-1:0] o_valid
);

    wb_slot_t r_slot [SLOT_DEPTH];

    // Insert is applied after the shift so it lands in the post-shift position.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int unsigned i = 0; i < SLOT_DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SLOT_DEPTH - 1; i++) begin
                r_slot[i] <= r_slot[i+1];
            end
            r_slot[SLOT_DEPTH-1] <= '0;
            if (i_ins_en) begin
                r_slot[i_ins_idx] <= i_ins_slot;
            end
        end
    end

    always_comb begin
        o_head = r_slot[0];
        for (int unsigned i = 0; i < SLOT_DEPTH; i++) begin
            o_valid[i] = r_slot[i].valid;
        end
    end

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FPU writeback scheduler: reserves FP writeback slots by unit latency,
// stalls on slot collisions, and runs toint through a single int stage.
module fpu_wb_scheduler
    import fpu_sched_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       io_req_valid,
    output logic       io_req_ready,
    input  logic [5:0] io_req_tag,
    input  logic       io_req_fma,
    input  logic       io_req_fastpipe,
    input  logic       io_req_fromint,
    input  logic       io_req_toint,
    input  logic       io_req_wflags,
    input  logic [1:0] io_req_typeTagOut,
    input  logic       io_kill,
    output logic       io_fp_wb_valid,
    output logic [5:0] io_fp_wb_tag,
    output logic [1:0] io_fp_wb_typeTag,
    output logic       io_fp_wb_wflags,
    output logic       io_int_wb_valid,
    output logic [5:0] io_int_wb_tag,
    output logic       io_int_wb_wflags,
    output logic       io_illegal,
    output logic       io_busy
);

    unit_e                 w_unit;
    logic                  w_two_cycle;
    logic                  w_collide;
    logic                  w_accept;
    logic                  w_ins_en;
    logic [SLOT_IDX_W-1:0] w_ins_idx;
    wb_slot_t              w_ins_slot;
    wb_slot_t              w_head;
    logic [SLOT_DEPTH-1:0] w_fp_valid;

    logic                  r_int_valid;
    logic [5:0]            r_int_tag;
    logic                  r_int_wflags;
    logic                  r_illegal;

    always_comb begin
        w_unit      = unit_select(io_req_fma, io_req_fastpipe, io_req_fromint, io_req_toint);
        w_two_cycle = (w_unit == FAST) || (w_unit == FROMINT);
        // Slot[2] now is the slot a 2-cycle uop would need after this edge's shift.
        w_collide    = w_two_cycle && w_fp_valid[FAST_LAT];
        io_req_ready = !reset && !io_kill && !w_collide;
        w_accept     = io_req_valid && io_req_ready;
        w_ins_en     = w_accept && ((w_unit == FMA) || w_two_cycle);
        case (w_unit)
            FMA:     w_ins_idx = SLOT_IDX_W'(FMA_LAT - 1);
            FROMINT: w_ins_idx = SLOT_IDX_W'(FROMINT_LAT - 1);
            default: w_ins_idx = SLOT_IDX_W'(FAST_LAT - 1);
        endcase
        w_ins_slot.valid    = 1'b1;
        w_ins_slot.tag      = io_req_tag;
        w_ins_slot.type_tag = io_req_typeTagOut;
        w_ins_slot.wflags   = io_req_wflags;
    end

    fpu_wb_shift_reg u_shift (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_clear    (io_kill),
        .i_ins_en   (w_ins_en),
        .i_ins_idx  (w_ins_idx),
        .i_ins_slot (w_ins_slot),
        .o_head     (w_head),
        .o_valid    (w_fp_valid)
    );

    always_ff @(posedge clock) begin
        if (reset || io_kill) begin
            r_int_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_int_valid <= w_accept && (w_unit == TOINT);
            r_illegal   <= w_accept && (w_unit == NONE);
        end
        r_int_tag    <= io_req_tag;
        r_int_wflags <= io_req_wflags;
    end

    always_comb begin
        io_fp_wb_valid   = w_head.valid;
        io_fp_wb_tag     = w_head.tag;
        io_fp_wb_typeTag = w_head.type_tag;
        io_fp_wb_wflags  = w_head.wflags;
        io_int_wb_valid  = r_int_valid;
        io_int_wb_tag    = r_int_tag;
        io_int_wb_wflags = r_int_wflags;
        io_illegal       = r_illegal;
        io_busy          = (|w_fp_valid) || r_int_valid;
    end

endmodule

// File: doc/fpu_wb_scheduler.md
FPU_WB_SCHEDULER -- requirements
Module: fpu_wb_scheduler

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port io_req_valid  input  1  decoded FPU uop offered.
REQ-004 SHALL have port io_req_ready  output  1  uop accepted this cycle when high with io_req_valid.
REQ-005 SHALL have port io_req_tag  input  6  uop tag carried to writeback.
REQ-006 SHALL have ports io_req_fma, io_req_fastpipe, io_req_fromint, io_req_toint, io_req_wflags  input  1 each  decoder signal bundle.
REQ-007 SHALL have port io_req_typeTagOut  input  2  output type tag.
REQ-008 SHALL have port io_kill  input  1  pipeline flush.
REQ-009 SHALL have ports io_fp_wb_valid  output  1, io_fp_wb_tag  output  6, io_fp_wb_typeTag  output  2, io_fp_wb_wflags  output  1  FP register-file writeback port.
REQ-010 SHALL have ports io_int_wb_valid  output  1, io_int_wb_tag  output  6, io_int_wb_wflags  output  1  integer writeback port.
REQ-011 SHALL have port io_illegal  output  1  one-cycle pulse for an accepted uop with no unit selected.
REQ-012 SHALL have port io_busy  output  1  any writeback reservation pending.

Function
REQ-013 Unit select priority SHALL be fma > fastpipe > fromint > toint; lower-priority bits are ignored when a higher one is set.
REQ-014 Latencies SHALL be fma 4, fastpipe 2, fromint 2, toint 1 cycles from acceptance edge to writeback-valid cycle.
REQ-015 FP port reservation SHALL be a 4-entry shift register slot[0..3] (valid, tag, typeTag, wflags); every cycle slot[i] <- slot[i+1], slot[3] <- empty.
REQ-016 A uop accepted in cycle T with FP latency L SHALL be written into slot[L-1] at the end of cycle T and appear on the FP port in cycle T+L.
REQ-017 io_fp_wb_* SHALL be driven directly from slot[0].
REQ-018 io_req_ready SHALL be low when io_kill is high, or when the selected unit is fastpipe/fromint and slot[2] is valid (a collision in cycle T+2); otherwise it SHALL be high.
REQ-019 fma SHALL never stall, because no slot[4] exists.
REQ-020 toint uops SHALL use a single registered stage and never stall; io_int_wb_valid SHALL be high in cycle T+1.
REQ-021 Each accepted uop SHALL produce exactly one writeback pulse, unless it is killed.
REQ-022 io_kill in cycle K SHALL clear all FP slots and the int stage at the end of cycle K; no writeback SHALL occur in cycle K+1 or later for uops accepted at or before K.
REQ-023 io_kill and io_req_valid in the same cycle SHALL accept nothing.
REQ-024 An accepted uop with none of the four unit bits set SHALL reserve nothing and SHALL pulse io_illegal in cycle T+1.
REQ-025 io_busy SHALL be the OR of all slot valids and the int-stage valid.
REQ-026 Data fields in empty slots are don't-care; checkers SHALL qualify them with valid.

Reset
REQ-027 While reset is high, all slot valids, the int-stage valid and io_illegal SHALL be cleared at the clock edge, and io_req_ready SHALL be low.
REQ-028 After reset deasserts, all outputs except io_req_ready SHALL be 0 in the first cycle; io_req_ready SHALL then follow REQ-018.
REQ-029 Reset asserted mid-operation SHALL discard all pending writebacks without emitting them.

Structure
REQ-030 The latency constants FMA_LAT=4, FAST_LAT=2, FROMINT_LAT=2 and TOINT_LAT=1 SHALL live in shared package fpu_sched_pkg.
REQ-031 The slot record type and the unit-select enum {NONE, FMA, FAST, FROMINT, TOINT} SHALL also live in fpu_sched_pkg.
REQ-032 The FP reservation shift register SHALL be a sub-module fpu_wb_shift_reg (depth 4, parallel insert at index, shift, clear).

Verification
REQ-033 fma tag 0x05 accepted cycle 10 -> io_fp_wb_valid=1, tag 0x05 in cycle 14 only.
REQ-034 fma tag 0x01 in cycle 10, fastpipe tag 0x02 in cycle 12 -> ready=0 in cycle 12; retried in cycle 13 and accepted, writes back in cycle 15; fma writes back in cycle 14.
REQ-035 toint tag 0x3F in cycle 20 with wflags=1 -> io_int_wb_valid=1, tag 0x3F, wflags=1 in cycle 21; FP port idle.
REQ-036 fma in cycle 30, io_kill in cycle 32 -> no FP writeback in cycles 33-34; io_busy=0 in cycle 33.
REQ-037 Uop with all unit bits 0 accepted in cycle 40 -> io_illegal=1 in cycle 41; io_busy stays 0.
REQ-038 fma and fromint both set, tag 0x0A, in cycle 50 -> treated as fma, single writeback in cycle 54.
